// File: rtl/spi_tx_phy_gen_if.sv
// Word-side bus of the SPI slave TX PHY.
// The protocol engine is the master; the PHY is the slave.
interface spi_tx_phy_gen_if #(
  parameter int DSIZE = 8
);
  logic [DSIZE-1:0] send_data;
  logic             send_valid;
  logic [23:0]      send_momment;
  logic             empty;
  logic             full;
  logic             underrun;

  modport master (
    output send_data,
    output send_valid,
    output send_momment,
    input  empty,
    input  full,
    input  underrun
  );

  modport slave (
    input  send_data,
    input  send_valid,
    input  send_momment,
    output empty,
    output full,
    output underrun
  );
endinterface

// File: rtl/spi_tx_phy_gen.sv
// SPI slave TX PHY: word FIFO to miso, sck/cs_n oversampled in the clock domain.
// Optional macro SPI_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module spi_tx_phy_gen #(
  parameter int   DSIZE     = 8,
  parameter int   DEPTH     = 4,
  parameter bit   CPOL      = 1'b0,
  parameter bit   CPHA      = 1'b0,
  parameter bit   LSB_FIRST = 1'b0,
  parameter logic IDLE_BIT  = 1'b1
) (
  input  logic clock,
  input  logic rst,
  input  logic sck,
  input  logic cs_n,
  output logic miso,
  output logic send_flag,
`ifdef SPI_TX_UNDERRUN_CNT_EN
  output logic [15:0] underrun_cnt,
`endif
  spi_tx_phy_gen_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [BW-1:0] LAST = BW'(DSIZE - 1);
  localparam logic [BW-1:0] ONE_B = BW'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);
  localparam logic [AW:0] ONE_C = (AW + 1)'(1);
  localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);
  localparam logic [DSIZE-1:0] IDLE_WORD = {DSIZE{IDLE_BIT}};
  localparam bit LAUNCH_RISE = CPOL ^ CPHA;

  logic [1:0]       sck_sync;
  logic [1:0]       cs_sync;
  logic             sck_d;
  logic             sck_s;
  logic             sel;
  logic             rise;
  logic             fall;
  logic             launch;

  logic [23:0]      edge_cnt;
  logic [23:0]      momment;
  logic             yield;
  logic             yield_set;
  logic             armed;
  logic             armed_nx;
  logic             at_last;
  logic             load;
  logic             shift;

  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_cnt_nx;
  logic [BW-1:0]    bit_idx;
  logic [DSIZE-1:0] shreg;
  logic [DSIZE-1:0] shreg_nx;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [DSIZE-1:0] data_in;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nx;
  logic             empty_r;
  logic             full_r;
  logic             underrun_r;
  logic             push;
  logic             pop;

  assign momment  = bus.send_momment;
  assign data_in  = bus.send_data;
  assign bus.empty    = empty_r;
  assign bus.full     = full_r;
  assign bus.underrun = underrun_r;

  // Two-flop synchronisers plus an sck history flop for edge detection.
  always_ff @(posedge clock) begin
    if (rst) begin
      sck_sync <= {2{CPOL}};
      sck_d    <= CPOL;
      cs_sync  <= 2'b11;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      sck_d    <= sck_sync[1];
      cs_sync  <= {cs_sync[0], cs_n};
    end
  end

  assign sck_s     = sck_sync[1];
  assign sel       = ~cs_sync[1];
  assign send_flag = sel;
  assign rise      = sck_s & ~sck_d;
  assign fall      = ~sck_s & sck_d;
  assign launch    = sel & (LAUNCH_RISE ? rise : fall);

  // Launch-edge counter since cs_n fell, saturating.
  always_ff @(posedge clock) begin
    if (rst || !sel) begin
      edge_cnt <= '0;
    end else if (launch && !(&edge_cnt)) begin
      edge_cnt <= edge_cnt + 24'd1;
    end
  end

  assign yield_set = sel & ~yield &
                     ((momment == 24'd0) | (edge_cnt >= momment));
  assign at_last   = (bit_cnt == LAST);

  // Load points: CPHA=0 preloads when yield rises; CPHA=1 loads on a launch.
  always_comb begin
    load = 1'b0;
    if (CPHA) begin
      load = launch & yield & (~armed | at_last);
    end else begin
      load = yield_set | (launch & yield & at_last);
    end
  end

  assign shift = launch & yield & ~load;
  assign pop   = load & ~empty_r;
  assign push  = bus.send_valid & ~full_r;

  // Next shifter state; miso is registered from these values.
  always_comb begin
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    armed_nx   = armed;
    if (load) begin
      shreg_nx   = empty_r ? IDLE_WORD : mem[rd_ptr];
      bit_cnt_nx = '0;
      armed_nx   = 1'b1;
    end else if (shift) begin
      bit_cnt_nx = at_last ? '0 : bit_cnt + ONE_B;
    end
    bit_idx = LSB_FIRST ? bit_cnt_nx : LAST - bit_cnt_nx;
  end

  // Shift register, bit counter, yield flag and registered miso.
  always_ff @(posedge clock) begin
    if (rst) begin
      shreg      <= IDLE_WORD;
      bit_cnt    <= '0;
      armed      <= 1'b0;
      yield      <= 1'b0;
      miso       <= IDLE_BIT;
      underrun_r <= 1'b0;
    end else if (!sel) begin
      bit_cnt    <= '0;
      armed      <= 1'b0;
      yield      <= 1'b0;
      miso       <= IDLE_BIT;
      underrun_r <= 1'b0;
    end else begin
      shreg      <= shreg_nx;
      bit_cnt    <= bit_cnt_nx;
      armed      <= armed_nx;
      if (yield_set) begin
        yield <= 1'b1;
      end
      miso       <= armed_nx ? shreg_nx[bit_idx] : IDLE_BIT;
      underrun_r <= load & empty_r;
    end
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    unique case ({push, pop})
      2'b10:   count_nx = count + ONE_C;
      2'b01:   count_nx = count - ONE_C;
      default: count_nx = count;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and registered flags.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_P;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_P;
      end
      count   <= count_nx;
      empty_r <= (count_nx == '0);
      full_r  <= (count_nx == FULL_C);
    end
  end

`ifdef SPI_TX_UNDERRUN_CNT_EN
  // Saturating count of underrun pulses.
  always_ff @(posedge clock) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun_r && !(&underrun_cnt)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_tx_phy_gen.sv
// Bench for spi_tx_phy_gen: three instances (mode 0, mode 3, mode 1 LSB-first 12-bit)
// sharing one abstract sck level, each with its own chip select.
module tb_spi_tx_phy_gen;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic lvl = 1'b0;
  logic [2:0] csn = 3'b111;
  logic [23:0] mom = '0;
  logic miso0, miso1, miso2;
  logic flag0, flag1, flag2;
`ifdef SPI_TX_UNDERRUN_CNT_EN
  logic [15:0] hc0, hc1, hc2;
`endif

  always #5 clock = ~clock;

  spi_tx_phy_gen_if #(.DSIZE(8))  if0 ();
  spi_tx_phy_gen_if #(.DSIZE(8))  if1 ();
  spi_tx_phy_gen_if #(.DSIZE(12)) if2 ();

  assign if0.send_momment = mom;
  assign if1.send_momment = mom;
  assign if2.send_momment = mom;

  spi_tx_phy_gen #(.DSIZE(8), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b0),
                   .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u0 (
    .clock(clock), .rst(rst), .sck(lvl), .cs_n(csn[0]),
    .miso(miso0), .send_flag(flag0),
`ifdef SPI_TX_UNDERRUN_CNT_EN
    .underrun_cnt(hc0),
`endif
    .bus(if0));

  spi_tx_phy_gen #(.DSIZE(8), .DEPTH(4), .CPOL(1'b1), .CPHA(1'b1),
                   .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u1 (
    .clock(clock), .rst(rst), .sck(~lvl), .cs_n(csn[1]),
    .miso(miso1), .send_flag(flag1),
`ifdef SPI_TX_UNDERRUN_CNT_EN
    .underrun_cnt(hc1),
`endif
    .bus(if1));

  spi_tx_phy_gen #(.DSIZE(12), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b1),
                   .LSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u2 (
    .clock(clock), .rst(rst), .sck(lvl), .cs_n(csn[2]),
    .miso(miso2), .send_flag(flag2),
`ifdef SPI_TX_UNDERRUN_CNT_EN
    .underrun_cnt(hc2),
`endif
    .bus(if2));

  int tests = 0;
  int fails = 0;
  int uc [3];
  int tot [3];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic got [$];
  logic exp_b [$];
  int exp_und;

  initial begin
    uc[0] = 0; uc[1] = 0; uc[2] = 0;
  end

  always @(posedge clock) begin
    if (if0.underrun) uc[0] <= uc[0] + 1;
    if (if1.underrun) uc[1] <= uc[1] + 1;
    if (if2.underrun) uc[2] <= uc[2] + 1;
  end

  function automatic int dsz(int k);
    return (k == 2) ? 12 : 8;
  endfunction

  function automatic bit cpha(int k);
    return k != 0;
  endfunction

  function automatic bit lsb(int k);
    return k == 2;
  endfunction

  function automatic logic miso_of(int k);
    return (k == 0) ? miso0 : (k == 1) ? miso1 : miso2;
  endfunction

  function automatic logic flag_of(int k);
    return (k == 0) ? flag0 : (k == 1) ? flag1 : flag2;
  endfunction

  function automatic logic empty_of(int k);
    return (k == 0) ? if0.empty : (k == 1) ? if1.empty : if2.empty;
  endfunction

  function automatic logic full_of(int k);
    return (k == 0) ? if0.full : (k == 1) ? if1.full : if2.full;
  endfunction

  function automatic logic und_of(int k);
    return (k == 0) ? if0.underrun : (k == 1) ? if1.underrun : if2.underrun;
  endfunction

  function automatic int qsz(int k);
    return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
  endfunction

  task automatic qpop(int k, output logic [31:0] w);
    if (k == 0) w = q0.pop_front();
    else if (k == 1) w = q1.pop_front();
    else w = q2.pop_front();
  endtask

  // Hold send_valid with word d for one clock; model accepts if not full.
  task automatic drive(int k, logic [31:0] d);
    logic [31:0] m;
    m = (k == 2) ? (d & 32'hFFF) : (d & 32'hFF);
    if (k == 0) begin if0.send_data = m[7:0]; if0.send_valid = 1'b1; end
    else if (k == 1) begin if1.send_data = m[7:0]; if1.send_valid = 1'b1; end
    else begin if2.send_data = m[11:0]; if2.send_valid = 1'b1; end
    if (qsz(k) < 4) begin
      if (k == 0) q0.push_back(m);
      else if (k == 1) q1.push_back(m);
      else q2.push_back(m);
    end
    @(negedge clock);
  endtask

  task automatic idle_bus();
    if0.send_valid = 1'b0;
    if1.send_valid = 1'b0;
    if2.send_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic push(int k, logic [31:0] d);
    drive(k, d);
    idle_bus();
  endtask

  // One frame of n sck cycles, sampling miso just before each sample edge.
  task automatic frame(int k, int n, int m);
    got.delete();
    mom = 24'(m);
    csn[k] = 1'b0;
    repeat (10) @(negedge clock);
    for (int i = 0; i < n; i++) begin
      if (!cpha(k)) got.push_back(miso_of(k));
      lvl = 1'b1;
      repeat (8) @(negedge clock);
      if (cpha(k)) got.push_back(miso_of(k));
      lvl = 1'b0;
      repeat (8) @(negedge clock);
    end
    csn[k] = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // Reference: data bits start after m launch edges; words are pulled
  // from the queue at every load point reached within n cycles.
  task automatic model(int k, int n, int m);
    int d;
    int loads;
    logic [31:0] w;
    logic s [$];
    d = dsz(k);
    exp_b.delete();
    exp_und = 0;
    if (!cpha(k)) loads = (n >= m) ? 1 + (n - m) / d : 0;
    else loads = (n > m) ? (n - m + d - 1) / d : 0;
    for (int l = 0; l < loads; l++) begin
      if (qsz(k) > 0) qpop(k, w);
      else begin w = '1; exp_und++; end
      for (int b = 0; b < d; b++)
        s.push_back(lsb(k) ? w[b] : w[d - 1 - b]);
    end
    for (int i = 0; i < n; i++)
      exp_b.push_back((i < m) ? 1'b1 : s[i - m]);
    tot[k] += exp_und;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (miso_of(k) !== 1'b1) begin fails++;
        $display("FAIL reset_miso[%0d]: got %b expected 1", k, miso_of(k)); end
      tests++;
      if (flag_of(k) !== 1'b0) begin fails++;
        $display("FAIL reset_flag[%0d]: got %b expected 0", k, flag_of(k)); end
      tests++;
      if (empty_of(k) !== 1'b1) begin fails++;
        $display("FAIL reset_empty[%0d]: got %b expected 1", k, empty_of(k)); end
      tests++;
      if (full_of(k) !== 1'b0) begin fails++;
        $display("FAIL reset_full[%0d]: got %b expected 0", k, full_of(k)); end
      tests++;
      if (und_of(k) !== 1'b0) begin fails++;
        $display("FAIL reset_underrun[%0d]: got %b expected 0", k, und_of(k)); end
    end
  endtask

  task automatic test_mode0_basic();
    int ub;
    push(0, 32'hA5);
    ub = uc[0];
    frame(0, 8, 0);
    model(0, 8, 0);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (got[i] !== exp_b[i]) begin fails++;
        $display("FAIL mode0 bit %0d: got %b expected %b", i, got[i], exp_b[i]); end
    end
    tests++;
    if (uc[0] - ub !== exp_und) begin fails++;
      $display("FAIL mode0 underruns: got %0d expected %0d", uc[0] - ub, exp_und); end
    tests++;
    if (empty_of(0) !== 1'b1) begin fails++;
      $display("FAIL mode0 empty: got %b expected 1", empty_of(0)); end
  endtask

  task automatic test_mode3_momment();
    int ub;
    push(1, 32'h3C);
    ub = uc[1];
    frame(1, 10, 2);
    model(1, 10, 2);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (got[i] !== exp_b[i]) begin fails++;
        $display("FAIL mode3 bit %0d: got %b expected %b", i, got[i], exp_b[i]); end
    end
    tests++;
    if (uc[1] - ub !== 0) begin fails++;
      $display("FAIL mode3 underruns: got %0d expected 0", uc[1] - ub); end
  endtask

  task automatic test_underrun();
    int ub;
    push(1, 32'($urandom));
    ub = uc[1];
    frame(1, 16, 0);
    model(1, 16, 0);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (got[i] !== exp_b[i]) begin fails++;
        $display("FAIL underrun bit %0d: got %b expected %b", i, got[i], exp_b[i]); end
    end
    tests++;
    if (uc[1] - ub !== 1) begin fails++;
      $display("FAIL underrun pulses: got %0d expected 1", uc[1] - ub); end
`ifdef SPI_TX_UNDERRUN_CNT_EN
    tests++;
    if (hc1 !== 16'(tot[1])) begin fails++;
      $display("FAIL underrun_cnt: got %0d expected %0d", hc1, tot[1]); end
`endif
  endtask

  task automatic test_fifo_full();
    int ub;
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'($urandom));
      tests++;
      if (full_of(0) !== (qsz(0) == 4)) begin fails++;
        $display("FAIL full after push %0d: got %b expected %b", i, full_of(0), qsz(0) == 4); end
    end
    idle_bus();
    tests++;
    if (qsz(0) != 4 || empty_of(0) !== 1'b0) begin fails++;
      $display("FAIL fifo fill: got empty %b expected 0", empty_of(0)); end
    ub = uc[0];
    frame(0, 32, 0);
    model(0, 32, 0);
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (got[i] !== exp_b[i]) begin fails++;
        $display("FAIL fifo order bit %0d: got %b expected %b", i, got[i], exp_b[i]); end
    end
    tests++;
    if (uc[0] - ub !== exp_und) begin fails++;
      $display("FAIL fifo underruns: got %0d expected %0d", uc[0] - ub, exp_und); end
  endtask

  task automatic test_cs_abort();
    int ub;
    push(0, 32'hF0);
    push(0, 32'($urandom));
    frame(0, 5, 0);
    model(0, 5, 0);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (got[i] !== exp_b[i]) begin fails++;
        $display("FAIL abort bit %0d: got %b expected %b", i, got[i], exp_b[i]); end
    end
    tests++;
    if (miso0 !== 1'b1) begin fails++;
      $display("FAIL abort idle: got %b expected 1", miso0); end
    ub = uc[0];
    frame(0, 8, 0);
    model(0, 8, 0);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (got[i] !== exp_b[i]) begin fails++;
        $display("FAIL abort next bit %0d: got %b expected %b", i, got[i], exp_b[i]); end
    end
    tests++;
    if (uc[0] - ub !== exp_und) begin fails++;
      $display("FAIL abort underruns: got %0d expected %0d", uc[0] - ub, exp_und); end
  endtask

  task automatic test_lsb_mode1();
    push(2, 32'h801);
    frame(2, 12, 0);
    model(2, 12, 0);
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (got[i] !== exp_b[i]) begin fails++;
        $display("FAIL lsb bit %0d: got %b expected %b", i, got[i], exp_b[i]); end
    end
  endtask

  task automatic test_random();
    int k, m, n, d, ub;
    for (int it = 0; it < 18; it++) begin
      k = $urandom_range(0, 2);
      d = dsz(k);
      m = $urandom_range(0, 3);
      n = m + d * $urandom_range(0, 2) + $urandom_range(1, d - 1);
      for (int p = $urandom_range(0, 3); p > 0; p--)
        push(k, 32'($urandom));
      ub = uc[k];
      frame(k, n, m);
      model(k, n, m);
      for (int i = 0; i < n; i++) begin
        tests++;
        if (got[i] !== exp_b[i]) begin fails++;
          $display("FAIL random it%0d dut%0d bit %0d: got %b expected %b",
                   it, k, i, got[i], exp_b[i]); end
      end
      tests++;
      if (uc[k] - ub !== exp_und) begin fails++;
        $display("FAIL random it%0d underruns: got %0d expected %0d",
                 it, uc[k] - ub, exp_und); end
      tests++;
      if (empty_of(k) !== (qsz(k) == 0)) begin fails++;
        $display("FAIL random it%0d empty: got %b expected %b",
                 it, empty_of(k), qsz(k) == 0); end
    end
  endtask

  task automatic test_reset_mid();
    push(0, 32'h5A);
    push(0, 32'h77);
    mom = '0;
    csn[0] = 1'b0;
    repeat (10) @(negedge clock);
    lvl = 1'b1;
    repeat (8) @(negedge clock);
    lvl = 1'b0;
    repeat (8) @(negedge clock);
    rst = 1'b1;
    csn[0] = 1'b1;
    @(negedge clock);
    q0.delete(); q1.delete(); q2.delete();
    tot[0] = 0; tot[1] = 0; tot[2] = 0;
    tests++;
    if (empty_of(0) !== 1'b1) begin fails++;
      $display("FAIL rst_mid empty: got %b expected 1", empty_of(0)); end
    tests++;
    if (miso0 !== 1'b1) begin fails++;
      $display("FAIL rst_mid miso: got %b expected 1", miso0); end
    tests++;
    if (flag0 !== 1'b0) begin fails++;
      $display("FAIL rst_mid flag: got %b expected 0", flag0); end
    repeat (2) @(negedge clock);
    rst = 1'b0;
    repeat (2) @(negedge clock);
    push(0, 32'hC3);
    frame(0, 8, 0);
    model(0, 8, 0);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (got[i] !== exp_b[i]) begin fails++;
        $display("FAIL rst_mid after bit %0d: got %b expected %b", i, got[i], exp_b[i]); end
    end
  endtask

  initial begin
    tot[0] = 0; tot[1] = 0; tot[2] = 0;
    if0.send_valid = 1'b0; if0.send_data = '0;
    if1.send_valid = 1'b0; if1.send_data = '0;
    if2.send_valid = 1'b0; if2.send_data = '0;
    @(negedge clock);
    test_reset();
    test_mode0_basic();
    test_mode3_momment();
    test_underrun();
    test_fifo_full();
    test_cs_abort();
    test_lsb_mode1();
    test_random();
    test_reset_mid();
`ifdef SPI_TX_UNDERRUN_CNT_EN
    tests++;
    if (hc0 !== 16'(tot[0])) begin fails++;
      $display("FAIL final underrun_cnt: got %0d expected %0d", hc0, tot[0]); end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
